display_framebuffer: RTL and testbench
======================================

# display_framebuffer

Double-buffered pixel store feeding `display_driver`. Host-side logic writes pixels or bulk-fills the back buffer and requests a swap; the display side addresses the front buffer with `display_driver`'s `row`/`column` and receives the 24-bit `pixel` one clock later. Swaps take effect only on `frame_complete`, so a displayed frame is never torn.

## Interface
- `rows`, 8: display rows per segment; power of two.
- `columns`, 32: pixels per row; power of two.
- `bitwidth`, 8: bits per colour channel; pixel width `PW = 3*bitwidth`, packed {r,g,b}.

- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-low reset.
- `row`  in  log2(rows)  display read row, from `display_driver`.
- `column`  in  log2(columns)  display read column, from `display_driver`.
- `frame_complete`  in  1  single-cycle pulse from `display_driver` at frame end.
- `pixel`  out  PW  front-buffer data for the previous cycle's `row`/`column`.
- `wr_en`  in  1  host write strobe; accepted only when `wr_ready`=1.
- `wr_row`  in  log2(rows)  host write row.
- `wr_column`  in  log2(columns)  host write column.
- `wr_data`  in  PW  host write pixel.
- `wr_ready`  out  1  high when IDLE and no swap is pending.
- `fill_start`  in  1  pulse; starts a bulk fill of the back buffer.
- `fill_data`  in  PW  fill value, sampled on the `fill_start` cycle.
- `fill_busy`  out  1  high while the fill runs.
- `swap_req`  in  1  pulse; request a front/back exchange.
- `swap_pending`  out  1  a swap is waiting for `frame_complete`.
- `swap_done`  out  1  one-cycle pulse after the swap takes effect.
- `front`  out  1  index of the buffer being displayed.

## Operation
- Storage: 2 × rows×columns words of PW bits. Address = {buffer, row, column}. Front = `front`; back = `!front`.
- Display read: synchronous, from the front buffer, with no stall.
- States: IDLE, FILL.
  - IDLE:
    - `wr_en`&`wr_ready` writes `wr_data` to back[{wr_row,wr_column}].
    - `fill_start` latches `fill_data`, clears the address counter, and goes to FILL.
  - FILL:
    - Writes the latched value to back[addr], addr = 0..rows×columns−1, one word per cycle.
    - After the last address, returns to IDLE.
    - `fill_start` is ignored while in FILL.
    - `wr_en` is ignored, because `wr_ready`=0.
- Swap:
  - `swap_req` sets `swap_pending`.
  - On a later cycle with `swap_pending`=1, `frame_complete`=1 and state IDLE: toggle `front`, clear `swap_pending`, and pulse `swap_done` on the next cycle.
  - `swap_req` while already pending has no extra effect.
  - `swap_req` during FILL is accepted. The swap waits for the fill to finish and then the next `frame_complete`.
  - `frame_complete` with no pending swap has no effect.
- Simultaneous events:
  - `swap_req` and `frame_complete` in the same cycle: the request is registered, and the swap waits for the next `frame_complete`.
  - `fill_start` and `wr_en` in the same IDLE cycle: the write is performed to its address, then the fill starts. The fill overwrites that address.
  - Fill on the last address in the same cycle as `frame_complete` with a swap pending: no swap that cycle, because state is not yet IDLE.
- `wr_ready` = (state==IDLE) & !`swap_pending`.

## Timing
- Read latency 1: `row`/`column` sampled at edge N gives `pixel` valid after edge N, using `front` as it was before edge N.
- Write latency: a host write at edge N is readable through the display port at edge N+1, once that buffer is front.
- Fill duration: exactly rows×columns cycles of `fill_busy`=1 (256 with defaults). `fill_busy` rises at the edge after the `fill_start` cycle.
- Swap: `front` toggles at the edge sampling `frame_complete`. `swap_done` is high for the following cycle only.
- Reset:
  - `pixel`=0, `wr_ready`=1, `fill_busy`=0, `swap_pending`=0, `swap_done`=0, `front`=0, state IDLE.
  - RAM contents are not reset.
  - Reset mid-fill or mid-swap aborts it immediately; partial fill data stays in RAM.

## Structure
- Shared package `display_pkg`: `PW` derivation, FILL/IDLE state encoding, address-width helpers (clog2 of rows/columns).
- Sub-module `framebuffer_ram`: simple dual-port RAM, one write port and one registered read port, depth 2×rows×columns, width PW, inferable as block RAM.
- Top level holds the FSM, fill counter, swap logic and write-port mux (host vs fill).

## Test plan
- Reset, then fill with 24'h123456, swap, wait for `frame_complete` → `front`=1, `swap_done` pulses once, every (row,column) reads 24'h123456 one cycle later.
- Write 24'hFF0000 to back (3,17), swap → after the swap, read (3,17) = 24'hFF0000 and neighbours are unchanged. Before the swap, front (3,17) still shows the old value.
- `swap_req` and `frame_complete` in the same cycle → `front` unchanged, `swap_pending`=1. The next `frame_complete` swaps.
- `swap_req` during a fill, with `frame_complete` pulsed every 50 cycles → no swap until `fill_busy` falls after exactly 256 cycles; the swap occurs on the first subsequent `frame_complete`.
- `wr_en` held high during FILL and during `swap_pending` → no writes land, `wr_ready`=0 throughout; a second `fill_start` mid-fill does not extend `fill_busy`.
- Assert `rst` mid-fill → all outputs return to reset values on the same cycle. A new fill of 24'h000001 and a swap then read correctly.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the double-buffered display framebuffer:
// pixel-width derivation, address-width helpers and FSM state encoding.
package display_pkg;

  localparam int unsigned DEF_ROWS     = 8;
  localparam int unsigned DEF_COLUMNS  = 32;
  localparam int unsigned DEF_BITWIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fb_state_e;

  function automatic int unsigned pix_width(input int unsigned bitwidth);
    return 3 * bitwidth;
  endfunction

  // Never returns 0 so a degenerate dimension still yields a legal port.
  function automatic int unsigned addr_bits(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/framebuffer_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register resets to zero so the display sees black out of reset.
module framebuffer_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 24,
  parameter int unsigned AW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) o_rdata <= '0;
    else      o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/display_framebuffer.sv
// Double-buffered pixel store: host writes/fills the back buffer, display reads
// the front buffer, and front/back exchange only on frame_complete.
module display_framebuffer
  import display_pkg::*;
#(
  parameter int unsigned rows     = DEF_ROWS,
  parameter int unsigned columns  = DEF_COLUMNS,
  parameter int unsigned bitwidth = DEF_BITWIDTH,
  localparam int unsigned PW = pix_width(bitwidth),
  localparam int unsigned RW = addr_bits(rows),
  localparam int unsigned CW = addr_bits(columns)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] column,
  input  logic          frame_complete,
  output logic [PW-1:0] pixel,
  input  logic          wr_en,
  input  logic [RW-1:0] wr_row,
  input  logic [CW-1:0] wr_column,
  input  logic [PW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          fill_start,
  input  logic [PW-1:0] fill_data,
  output logic          fill_busy,
  input  logic          swap_req,
  output logic          swap_pending,
  output logic          swap_done,
  output logic          front
);

  localparam int unsigned FA    = RW + CW;
  localparam int unsigned AW    = 1 + FA;
  localparam int unsigned DEPTH = 2 * rows * columns;
  localparam logic [FA-1:0] LAST_ADDR = FA'(rows * columns - 1);

  fb_state_e     r_state;
  logic [FA-1:0] r_fill_addr;
  logic [PW-1:0] r_fill_data;
  logic          r_front;
  logic          r_swap_pending;
  logic          r_swap_done;
  logic          r_wr_ready;
  logic          r_fill_busy;

  fb_state_e     w_next_state;
  logic          w_next_pending;
  logic          w_do_swap;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [PW-1:0] w_wdata;
  logic [PW-1:0] w_rd_data;

  // Next-state, swap decision and write-port mux (host write vs fill engine).
  always_comb begin
    w_next_state   = r_state;
    w_next_pending = r_swap_pending;
    w_do_swap      = 1'b0;
    w_we           = 1'b0;
    w_waddr        = '0;
    w_wdata        = '0;
    case (r_state)
      ST_IDLE: begin
        if (wr_en && r_wr_ready) begin
          w_we    = 1'b1;
          w_waddr = {~r_front, wr_row, wr_column};
          w_wdata = wr_data;
        end
        if (fill_start) w_next_state = ST_FILL;
        if (r_swap_pending && frame_complete) w_do_swap = 1'b1;
      end
      ST_FILL: begin
        w_we    = 1'b1;
        w_waddr = {~r_front, r_fill_addr};
        w_wdata = r_fill_data;
        if (r_fill_addr == LAST_ADDR) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (w_do_swap)     w_next_pending = 1'b0;
    else if (swap_req) w_next_pending = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_fill_addr    <= '0;
      r_fill_data    <= '0;
      r_front        <= 1'b0;
      r_swap_pending <= 1'b0;
      r_swap_done    <= 1'b0;
      r_wr_ready     <= 1'b1;
      r_fill_busy    <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_swap_pending <= w_next_pending;
      r_swap_done    <= w_do_swap;
      r_wr_ready     <= (w_next_state == ST_IDLE) && !w_next_pending;
      r_fill_busy    <= (w_next_state == ST_FILL);
      if (w_do_swap) r_front <= ~r_front;
      if (r_state == ST_IDLE && fill_start) begin
        r_fill_addr <= '0;
        r_fill_data <= fill_data;
      end else if (r_state == ST_FILL) begin
        r_fill_addr <= r_fill_addr + FA'(1);
      end
    end
  end

  // Display reads always target the front buffer as it stands before the edge.
  framebuffer_ram #(
    .DEPTH(DEPTH),
    .WIDTH(PW),
    .AW   (AW)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_raddr({r_front, row, column}),
    .o_rdata(w_rd_data)
  );

  assign pixel        = w_rd_data;
  assign wr_ready     = r_wr_ready;
  assign fill_busy    = r_fill_busy;
  assign swap_pending = r_swap_pending;
  assign swap_done    = r_swap_done;
  assign front        = r_front;

endmodule

// File: tb/tb_display_framebuffer.sv
// Self-checking bench for display_framebuffer: a per-cycle behavioural model
// compared on every falling edge, plus directed scenarios with literal checks.
module tb_display_framebuffer;

  logic        clk;
  logic        rst;
  logic [2:0]  row;
  logic [4:0]  column;
  logic        frame_complete;
  logic [23:0] pixel;
  logic        wr_en;
  logic [2:0]  wr_row;
  logic [4:0]  wr_column;
  logic [23:0] wr_data;
  logic        wr_ready;
  logic        fill_start;
  logic [23:0] fill_data;
  logic        fill_busy;
  logic        swap_req;
  logic        swap_pending;
  logic        swap_done;
  logic        front;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 0;

  display_framebuffer dut (
    .clk           (clk),
    .rst           (rst),
    .row           (row),
    .column        (column),
    .frame_complete(frame_complete),
    .pixel         (pixel),
    .wr_en         (wr_en),
    .wr_row        (wr_row),
    .wr_column     (wr_column),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .fill_start    (fill_start),
    .fill_data     (fill_data),
    .fill_busy     (fill_busy),
    .swap_req      (swap_req),
    .swap_pending  (swap_pending),
    .swap_done     (swap_done),
    .front         (front)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory image with known-bits, fill as "words remaining".
  logic [23:0] m_mem   [512];
  bit          m_valid [512];
  int          m_front, m_fill_left, m_fill_idx;
  bit          m_pending, m_swap_done, m_wr_ready, m_fill_busy, m_pix_known;
  logic [23:0] m_fill_val, m_pix;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_front = 0; m_pending = 0; m_swap_done = 0; m_wr_ready = 1; m_fill_busy = 0;
      m_fill_left = 0; m_fill_idx = 0; m_pix = '0; m_pix_known = 1;
    end else begin : step
      int ra, wa;
      bit swapped;
      swapped = 0;
      ra = m_front * 256 + int'(row) * 32 + int'(column);
      m_pix_known = m_valid[ra];
      m_pix = m_mem[ra];
      if (m_fill_left > 0) begin
        wa = (1 - m_front) * 256 + m_fill_idx;
        m_mem[wa] = m_fill_val; m_valid[wa] = 1;
        m_fill_idx++; m_fill_left--;
      end else begin
        if (wr_en && m_wr_ready) begin
          wa = (1 - m_front) * 256 + int'(wr_row) * 32 + int'(wr_column);
          m_mem[wa] = wr_data; m_valid[wa] = 1;
        end
        if (m_pending && frame_complete) begin
          m_front = 1 - m_front; m_pending = 0; swapped = 1;
        end
        if (fill_start) begin
          m_fill_val = fill_data; m_fill_idx = 0; m_fill_left = 256;
        end
      end
      if (swap_req && !swapped) m_pending = 1;
      m_swap_done = swapped;
      m_fill_busy = (m_fill_left > 0);
      m_wr_ready  = !m_fill_busy && !m_pending;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      if (m_pix_known) chk("pixel", 32'(pixel), 32'(m_pix));
      chk("front", 32'(front), 32'(m_front));
      chk("swap_pending", 32'(swap_pending), 32'(m_pending));
      chk("swap_done", 32'(swap_done), 32'(m_swap_done));
      chk("wr_ready", 32'(wr_ready), 32'(m_wr_ready));
      chk("fill_busy", 32'(fill_busy), 32'(m_fill_busy));
    end
  end

  task automatic start_fill(input logic [23:0] val, output int busy_cycles);
    fill_start = 1'b1; fill_data = val;
    @(negedge clk);
    fill_start = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 400 && fill_busy; i++) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic do_swap(output int pulses);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0; frame_complete = 1'b1;
    @(negedge clk);
    frame_complete = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (swap_done) pulses++;
      @(negedge clk);
    end
  endtask

  task automatic rd(input int r, input int c, output logic [23:0] d);
    row = 3'(r); column = 5'(c);
    @(negedge clk);
    d = pixel;
  endtask

  task automatic sweep();
    for (int i = 0; i < 256; i++) begin
      row = 3'(i / 32); column = 5'(i % 32);
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt, pulses, busy_cnt, fall_at, tog_at, rdy_hi;
    logic [23:0] d;
    logic f0;
    rst = 1'b0; row = '0; column = '0; frame_complete = 1'b0;
    wr_en = 1'b0; wr_row = '0; wr_column = '0; wr_data = '0;
    fill_start = 1'b0; fill_data = '0; swap_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pixel", 32'(pixel), 32'h0);
    chk("rst_wr_ready", 32'(wr_ready), 32'h1);
    chk("rst_fill_busy", 32'(fill_busy), 32'h0);
    chk("rst_front", 32'(front), 32'h0);
    chk("rst_swap_pending", 32'(swap_pending), 32'h0);
    chk("rst_swap_done", 32'(swap_done), 32'h0);
    cmp_en = 1;
    rst = 1'b1;
    @(negedge clk);

    // Fill, swap, sweep
    start_fill(24'h123456, cnt);
    chk("fill1_cycles", 32'(cnt), 32'd256);
    do_swap(pulses);
    chk("swap1_pulses", 32'(pulses), 32'd1);
    chk("swap1_front", 32'(front), 32'h1);
    sweep();
    rd(7, 31, d);
    chk("fill1_read_7_31", 32'(d), 32'h123456);

    // Single write into a known back buffer
    start_fill(24'h0000AA, cnt);
    wr_en = 1'b1; wr_row = 3'd3; wr_column = 5'd17; wr_data = 24'hFF0000;
    @(negedge clk);
    wr_en = 1'b0;
    rd(3, 17, d);
    chk("preswap_front_3_17", 32'(d), 32'h123456);
    do_swap(pulses);
    chk("swap2_front", 32'(front), 32'h0);
    rd(3, 17, d);
    chk("write_3_17", 32'(d), 32'hFF0000);
    rd(3, 16, d);
    chk("neigh_3_16", 32'(d), 32'h0000AA);
    rd(2, 17, d);
    chk("neigh_2_17", 32'(d), 32'h0000AA);
    rd(4, 17, d);
    chk("neigh_4_17", 32'(d), 32'h0000AA);

    // swap_req coincident with frame_complete
    swap_req = 1'b1; frame_complete = 1'b1;
    @(negedge clk);
    swap_req = 1'b0; frame_complete = 1'b0;
    chk("coinc_pending", 32'(swap_pending), 32'h1);
    chk("coinc_front", 32'(front), 32'h0);
    frame_complete = 1'b1;
    @(negedge clk);
    frame_complete = 1'b0;
    chk("coinc_next_front", 32'(front), 32'h1);
    chk("coinc_next_pending", 32'(swap_pending), 32'h0);

    // Swap during fill, periodic frame_complete, write attempts, second fill_start
    f0 = front; busy_cnt = 0; fall_at = -1; tog_at = -1; rdy_hi = 0;
    for (int i = 0; i < 400; i++) begin
      fill_start = (i == 0) || (i == 100);
      fill_data = (i == 0) ? 24'h00BEEF : 24'h999999;
      swap_req = (i == 10);
      frame_complete = (i % 50 == 49);
      wr_en = (i < 299); wr_row = 3'd3; wr_column = 5'd17; wr_data = 24'hDEAD00;
      @(negedge clk);
      if (fill_busy) busy_cnt++;
      else if (fall_at < 0) fall_at = i;
      if (front != f0 && tog_at < 0) tog_at = i;
      if (i < 299 && wr_ready) rdy_hi++;
    end
    fill_start = 1'b0; swap_req = 1'b0; frame_complete = 1'b0; wr_en = 1'b0;
    chk("fill3_busy_cycles", 32'(busy_cnt), 32'd256);
    chk("fill3_fall_index", 32'(fall_at), 32'd256);
    chk("fill3_swap_index", 32'(tog_at), 32'd299);
    chk("fill3_wr_ready_high", 32'(rdy_hi), 32'd0);
    rd(3, 17, d);
    chk("fill3_no_write_3_17", 32'(d), 32'h00BEEF);

    // Reset in the middle of a fill with a swap pending
    fill_start = 1'b1; fill_data = 24'h777777;
    @(negedge clk);
    fill_start = 1'b0; swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    repeat (20) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_fill_busy", 32'(fill_busy), 32'h0);
    chk("midrst_wr_ready", 32'(wr_ready), 32'h1);
    chk("midrst_swap_pending", 32'(swap_pending), 32'h0);
    chk("midrst_pixel", 32'(pixel), 32'h0);
    chk("midrst_front", 32'(front), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_fill(24'h000001, cnt);
    chk("fill4_cycles", 32'(cnt), 32'd256);
    do_swap(pulses);
    chk("swap4_pulses", 32'(pulses), 32'd1);
    chk("swap4_front", 32'(front), 32'h1);
    rd(0, 0, d);
    chk("fill4_read_0_0", 32'(d), 32'h000001);
    rd(5, 9, d);
    chk("fill4_read_5_9", 32'(d), 32'h000001);
    sweep();

    @(negedge clk);
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
